// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG step scheduler.
// State encoding, default seed and datapath widths.
package prng_pkg;

  localparam int unsigned SEED_W   = 16;
  localparam int unsigned SAMPLE_W = 8;

  localparam logic [SEED_W-1:0] PRNG_DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSeed = 2'd1,
    StWarm = 2'd2,
    StRun  = 2'd3
  } prng_state_e;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEED = 2'd1;
  localparam logic [1:0] WARM = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

endpackage

// File: rtl/prng_prescaler.sv
// Free-running divider: counts 0..DIV-1 while enabled and pulses tick_o on the last count.
// clr holds the count at zero; a held count produces no tick.
module prng_prescaler #(
  parameter int unsigned W   = 24,
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick_o
);

  localparam logic [W-1:0] Last = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic         at_last;

  assign at_last = (cnt_q == Last);
  assign tick_o  = en && at_last;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= at_last ? '0 : cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/prng_step_ctrl.sv
// Single-clock step scheduler for the PRNG datapath: seed load, warm-up, prescaled stepping,
// and a valid/ack sample register. Define PRNG_STEP_CTRL_STATUS_EN for the status counters.
module prng_step_ctrl
  import prng_pkg::*;
#(
  parameter int unsigned DIV_W       = 24,
  parameter int unsigned DATA_DIV    = 10_000_000,
  parameter int unsigned CTRL_DIV    = 2_500_000,
  parameter int unsigned SEED_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                run_i,
  input  logic                step_i,
  input  logic                seed_load_i,
  input  logic [SEED_W-1:0]   seed_i,
  input  logic [SAMPLE_W-1:0] mux_in_i,
  input  logic                sample_ack_i,
  output logic                data_step_o,
  output logic                ctrl_step_o,
  output logic                seed_we_o,
  output logic [SEED_W-1:0]   seed_o,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  output logic                overrun_o,
  output logic [1:0]          state_o
`ifdef PRNG_STEP_CTRL_STATUS_EN
  ,
  output logic [7:0]          overrun_cnt_o,
  output logic [15:0]         step_cnt_o
`endif
);

  localparam int unsigned WarmW = (SEED_CYCLES > 1) ? $clog2(SEED_CYCLES) : 1;
  localparam logic [WarmW-1:0] WarmLast = WarmW'(SEED_CYCLES - 1);

  prng_state_e         state_q, state_d;
  logic [WarmW-1:0]    warm_cnt_q, warm_cnt_d;
  logic [SEED_W-1:0]   seed_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                valid_q, overrun_q;
  logic                step_req_q, step_req_d;
  logic                capture_pend_q, capture_pend_d;

  logic in_run, presc_clr, presc_en;
  logic data_tick, ctrl_tick;
  logic run_data_step, run_ctrl_step;
  logic capture;

  assign in_run    = en && (state_q == StRun);
  assign presc_clr = (state_q != StRun);
  assign presc_en  = in_run && run_i;

  prng_prescaler #(
    .W   (DIV_W),
    .DIV (DATA_DIV)
  ) u_data_presc (
    .clk    (clk),
    .reset  (reset),
    .clr    (presc_clr),
    .en     (presc_en),
    .tick_o (data_tick)
  );

  prng_prescaler #(
    .W   (DIV_W),
    .DIV (CTRL_DIV)
  ) u_ctrl_presc (
    .clk    (clk),
    .reset  (reset),
    .clr    (presc_clr),
    .en     (presc_en),
    .tick_o (ctrl_tick)
  );

  // Next state: en and seed reload take priority over the normal sequence.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = StIdle;
    end else if (seed_load_i && (state_q != StIdle)) begin
      state_d = StSeed;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StSeed;
        StSeed:  state_d = StWarm;
        StWarm:  if (warm_cnt_q == WarmLast) state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    warm_cnt_d = '0;
    if ((state_q == StWarm) && (state_d == StWarm)) begin
      warm_cnt_d = warm_cnt_q + WarmW'(1);
    end
  end

  // A single-step request is honoured in the following cycle.
  assign step_req_d = in_run && !run_i && step_i;

  assign run_data_step = in_run && (data_tick || step_req_q);
  assign run_ctrl_step = in_run && (ctrl_tick || step_req_q);

  assign data_step_o = (en && (state_q == StWarm)) || run_data_step;
  assign ctrl_step_o = (en && (state_q == StWarm)) || run_ctrl_step;
  assign seed_we_o   = en && (state_q == StSeed);
  assign seed_o      = seed_we_o ? seed_q : '0;

  // Capture the post-step mux value one cycle later, unless we are leaving RUN.
  assign capture_pend_d = run_data_step && (state_d == StRun);
  assign capture        = capture_pend_q && en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StIdle;
      warm_cnt_q     <= '0;
      seed_q         <= PRNG_DEFAULT_SEED;
      step_req_q     <= 1'b0;
      capture_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      warm_cnt_q     <= warm_cnt_d;
      step_req_q     <= step_req_d;
      capture_pend_q <= capture_pend_d;
      if (en && seed_load_i) begin
        seed_q <= seed_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else if (capture) begin
      sample_q <= mux_in_i;
      valid_q  <= 1'b1;
      if (valid_q && !sample_ack_i) begin
        overrun_q <= 1'b1;
      end
    end else if (sample_ack_i && valid_q) begin
      valid_q <= 1'b0;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign overrun_o      = overrun_q;
  assign state_o        = state_q;

`ifdef PRNG_STEP_CTRL_STATUS_EN
  logic [7:0]  overrun_cnt_q;
  logic [15:0] step_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_cnt_q <= '0;
      step_cnt_q    <= '0;
    end else begin
      if (capture && valid_q && !sample_ack_i && (overrun_cnt_q != 8'hFF)) begin
        overrun_cnt_q <= overrun_cnt_q + 8'd1;
      end
      if (state_q == StSeed) begin
        step_cnt_q <= '0;
      end else if (run_data_step) begin
        step_cnt_q <= step_cnt_q + 16'd1;
      end
    end
  end

  assign overrun_cnt_o = overrun_cnt_q;
  assign step_cnt_o    = step_cnt_q;
`endif

endmodule
